// File: rtl/aes128_dec_key_sched.sv
// Sequential AES-128 round-key generator: emits round keys 10..0 (or 0..10 with
// FWD_ORDER=1) over a valid/ready handshake, holding only the current key.
module aes128_dec_key_sched #(
  parameter int unsigned FWD_ORDER = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [0:127] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic [0:127] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_last,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy
);

  localparam bit INV = (FWD_ORDER == 0);

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, EXPAND, EMIT} state_t;

  state_t       state, state_n;
  logic [0:127] kreg, kreg_n, step;
  logic [3:0]   rc, rc_n, rcon_idx;
  logic [7:0]   rcon;
  logic [0:31]  w0, w1, w2, w3, p3, sub_in, rot, sub_out, t, f0, f1, f2, f3;
  logic         use_inv, last;

  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  assign {w0, w1, w2, w3} = kreg;
  assign p3      = w3 ^ w2;
  assign use_inv = (state == EMIT) && INV;

  // Single SubWord unit: inverse step feeds the recovered previous w3 (p3).
  assign sub_in  = use_inv ? p3 : w3;
  assign rot     = {sub_in[8:31], sub_in[0:7]};
  assign sub_out = {sb(rot[0:7]), sb(rot[8:15]), sb(rot[16:23]), sb(rot[24:31])};

  assign rcon_idx = use_inv ? rc : rc + 4'd1;

  always_comb begin
    rcon = 8'h00;
    case (rcon_idx)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign t  = sub_out ^ {rcon, 24'h000000};
  assign f0 = w0 ^ t;
  assign f1 = f0 ^ w1;
  assign f2 = f1 ^ w2;
  assign f3 = f2 ^ w3;
  assign step = use_inv ? {w0 ^ t, w1 ^ w0, w2 ^ w1, p3} : {f0, f1, f2, f3};

  assign last = (state == EMIT) && (INV ? (rc == 4'd0) : (rc == 4'd10));

  always_comb begin
    state_n = state;
    kreg_n  = kreg;
    rc_n    = rc;
    unique case (state)
      IDLE: if (key_valid) begin
        kreg_n  = key_in;
        rc_n    = '0;
        state_n = INV ? EXPAND : EMIT;
      end
      EXPAND: begin
        kreg_n = step;
        rc_n   = rc + 4'd1;
        if (rc == 4'd9) state_n = EMIT;
      end
      EMIT: if (rk_ready) begin
        if (last) begin
          state_n = IDLE;
        end else begin
          kreg_n = step;
          rc_n   = INV ? rc - 4'd1 : rc + 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      kreg  <= '0;
      rc    <= '0;
    end else begin
      state <= state_n;
      kreg  <= kreg_n;
      rc    <= rc_n;
    end
  end

  assign key_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rk_valid  = (state == EMIT);
  assign rk_last   = last;
  assign rk_out    = kreg;
  assign rk_round  = rc;

endmodule

// File: tb/tb_aes128_dec_key_sched.sv
// Bench for aes128_dec_key_sched: decrypt-order and encrypt-order instances checked
// against a FIPS-197 key expansion model built on a GF(2^8)-derived S-box.
module tb_aes128_dec_key_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_valid = 1'b0;
  logic rk_ready = 1'b1;
  logic sel = 1'b0;
  logic [127:0] key_in = '0;

  logic key_ready0, rk_last0, rk_valid0, busy0, key_ready1, rk_last1, rk_valid1, busy1;
  logic [127:0] rk_out0, rk_out1;
  logic [3:0] rk_round0, rk_round1;
  logic kv0, kv1;
  logic m_key_ready, m_rk_last, m_rk_valid, m_busy;
  logic [127:0] m_rk_out;
  logic [3:0] m_rk_round;

  assign kv0 = key_valid & ~sel;
  assign kv1 = key_valid & sel;
  assign m_key_ready = sel ? key_ready1 : key_ready0;
  assign m_rk_last   = sel ? rk_last1   : rk_last0;
  assign m_rk_valid  = sel ? rk_valid1  : rk_valid0;
  assign m_busy      = sel ? busy1      : busy0;
  assign m_rk_out    = sel ? rk_out1    : rk_out0;
  assign m_rk_round  = sel ? rk_round1  : rk_round0;

  aes128_dec_key_sched #(.FWD_ORDER(0)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(kv0), .key_ready(key_ready0),
    .rk_out(rk_out0), .rk_round(rk_round0), .rk_last(rk_last0), .rk_valid(rk_valid0),
    .rk_ready(rk_ready), .busy(busy0)
  );

  aes128_dec_key_sched #(.FWD_ORDER(1)) dut_fwd (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(kv1), .key_ready(key_ready1),
    .rk_out(rk_out1), .rk_round(rk_round1), .rk_last(rk_last1), .rk_valid(rk_valid1),
    .rk_ready(rk_ready), .busy(busy1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [7:0]   sbt [256];
  logic [127:0] exp_rk [11];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] b);
    logic [7:0] x;
    x = 8'h01;
    for (int i = 0; i < 254; i++) x = gmul(x, b);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  task automatic compute_ref(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] tw;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tw = w[i-1];
      if (i % 4 == 0) begin
        tw = {tw[23:0], tw[31:24]};
        tw = {sbt[tw[31:24]], sbt[tw[23:16]], sbt[tw[15:8]], sbt[tw[7:0]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ tw;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- stimulus / collection ----------------
  logic [127:0] got_rk [16];
  logic [3:0]   got_round [16];
  logic         got_last [16];
  int           got_cyc [16];
  int n_hs, stall_viol, timed_out, cyc;

  task automatic send_key(input logic [127:0] k, output int ok);
    int b;
    b = 0;
    while (!m_key_ready && b < 50) begin @(posedge clk); #1; b++; end
    ok = m_key_ready;
    key_in = k;
    key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic collect(input int stall_pct, input int stop_round);
    logic stalled, done, h_last;
    logic [127:0] h_rk;
    logic [3:0] h_round;
    int budget;
    n_hs = 0; stall_viol = 0; timed_out = 0; cyc = 1;
    stalled = 0; done = 0; budget = 0;
    h_rk = '0; h_round = '0; h_last = 0;
    while (!done) begin
      rk_ready = ($urandom_range(99) >= stall_pct);
      if (stalled && (m_rk_valid !== 1'b1 || m_rk_out !== h_rk || m_rk_round !== h_round
                      || m_rk_last !== h_last)) stall_viol++;
      stalled = 0;
      if (m_rk_valid === 1'b1) begin
        if (rk_ready) begin
          if (n_hs < 16) begin
            got_rk[n_hs] = m_rk_out; got_round[n_hs] = m_rk_round;
            got_last[n_hs] = m_rk_last; got_cyc[n_hs] = cyc;
          end
          n_hs++;
          if (m_rk_last === 1'b1 || int'(m_rk_round) == stop_round) done = 1;
        end else begin
          stalled = 1; h_rk = m_rk_out; h_round = m_rk_round; h_last = m_rk_last;
        end
      end
      @(posedge clk); #1;
      cyc++; budget++;
      if (!done && budget > 300) begin timed_out = 1; done = 1; end
    end
    rk_ready = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (key_ready0 !== 1'b1) begin errors++; $display("FAIL reset_key_ready got %b exp 1", key_ready0); end
    checks++; if (rk_valid0 !== 1'b0) begin errors++; $display("FAIL reset_rk_valid got %b exp 0", rk_valid0); end
    checks++; if (rk_last0 !== 1'b0) begin errors++; $display("FAIL reset_rk_last got %b exp 0", rk_last0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy0); end
    checks++; if (rk_out0 !== '0) begin errors++; $display("FAIL reset_rk_out got %h exp 0", rk_out0); end
    checks++; if (rk_round0 !== 4'd0) begin errors++; $display("FAIL reset_rk_round got %0d exp 0", rk_round0); end
    checks++; if (key_ready1 !== 1'b1 || rk_valid1 !== 1'b0 || busy1 !== 1'b0 || rk_out1 !== '0)
      begin errors++; $display("FAIL reset_fwd got ready=%b valid=%b busy=%b out=%h exp 1 0 0 0", key_ready1, rk_valid1, busy1, rk_out1); end
  endtask

  task automatic test_decrypt_order;
    logic [127:0] k;
    int ok;
    k = 128'h000102030405060708090a0b0c0d0e0f;
    compute_ref(k);
    checks++; if (exp_rk[10] !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin errors++; $display("FAIL model_round10 got %h exp 13111d7fe3944a17f307a78b4d2b30c5", exp_rk[10]); end
    send_key(k, ok);
    checks++; if (ok !== 1) begin errors++; $display("FAIL dec_key_accept got %0d exp 1", ok); end
    collect(0, -1);
    checks++; if (timed_out !== 0 || n_hs !== 11) begin errors++; $display("FAIL dec_count got %0d (timeout %0d) exp 11", n_hs, timed_out); end
    checks++; if (got_cyc[0] !== 11) begin errors++; $display("FAIL dec_latency got %0d exp 11", got_cyc[0]); end
    checks++; if (got_rk[0] !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin errors++; $display("FAIL dec_round10 got %h exp 13111d7fe3944a17f307a78b4d2b30c5", got_rk[0]); end
    checks++; if (got_rk[9] !== 128'hd6aa74fdd2af72fadaa678f1d6ab76fe || got_cyc[9] !== 20) begin errors++; $display("FAIL dec_round1 got %h @%0d exp d6aa74fdd2af72fadaa678f1d6ab76fe @20", got_rk[9], got_cyc[9]); end
    checks++; if (got_rk[10] !== k || got_last[10] !== 1'b1 || got_cyc[10] !== 21) begin errors++; $display("FAIL dec_round0 got %h last=%b @%0d exp %h last=1 @21", got_rk[10], got_last[10], got_cyc[10], k); end
    checks++; if (key_ready0 !== 1'b1) begin errors++; $display("FAIL dec_key_ready_after got %b exp 1 at cycle 22", key_ready0); end
    for (int i = 0; i < 11; i++) begin
      checks++; if (got_rk[i] !== exp_rk[10-i] || got_round[i] !== 4'(10-i) || got_last[i] !== (i == 10))
        begin errors++; $display("FAIL dec_seq[%0d] got %h r%0d l%b exp %h r%0d l%b", i, got_rk[i], got_round[i], got_last[i], exp_rk[10-i], 10-i, i == 10); end
    end
  endtask

  task automatic test_stall(input logic [127:0] k, input int pct, input int fixed);
    int ok;
    compute_ref(k);
    send_key(k, ok);
    collect(pct, -1);
    checks++; if (ok !== 1 || timed_out !== 0 || n_hs !== 11) begin errors++; $display("FAIL stall_count got %0d (ok %0d timeout %0d) exp 11", n_hs, ok, timed_out); end
    checks++; if (stall_viol !== 0) begin errors++; $display("FAIL stall_hold got %0d changes exp 0", stall_viol); end
    if (fixed != 0) begin
      checks++; if (got_rk[0] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin errors++; $display("FAIL stall_round10 got %h exp d014f9a8c9ee2589e13f0cc8b6630ca6", got_rk[0]); end
      checks++; if (got_rk[9] !== 128'ha0fafe1788542cb123a339392a6c7605) begin errors++; $display("FAIL stall_round1 got %h exp a0fafe1788542cb123a339392a6c7605", got_rk[9]); end
    end
    for (int i = 0; i < 11; i++) begin
      checks++; if (got_rk[i] !== exp_rk[10-i] || got_round[i] !== 4'(10-i) || got_last[i] !== (i == 10))
        begin errors++; $display("FAIL stall_seq[%0d] got %h r%0d l%b exp %h r%0d", i, got_rk[i], got_round[i], got_last[i], exp_rk[10-i], 10-i); end
    end
  endtask

  task automatic test_fwd_order(input logic [127:0] k, input int pct);
    int ok;
    sel = 1'b1;
    compute_ref(k);
    send_key(k, ok);
    collect(pct, -1);
    checks++; if (ok !== 1 || timed_out !== 0 || n_hs !== 11) begin errors++; $display("FAIL fwd_count got %0d (ok %0d timeout %0d) exp 11", n_hs, ok, timed_out); end
    checks++; if (stall_viol !== 0) begin errors++; $display("FAIL fwd_hold got %0d changes exp 0", stall_viol); end
    if (pct == 0) begin
      checks++; if (got_cyc[0] !== 1 || got_cyc[10] !== 11) begin errors++; $display("FAIL fwd_timing got %0d/%0d exp 1/11", got_cyc[0], got_cyc[10]); end
    end
    for (int i = 0; i < 11; i++) begin
      checks++; if (got_rk[i] !== exp_rk[i] || got_round[i] !== 4'(i) || got_last[i] !== (i == 10))
        begin errors++; $display("FAIL fwd_seq[%0d] got %h r%0d l%b exp %h r%0d", i, got_rk[i], got_round[i], got_last[i], exp_rk[i], i); end
    end
    sel = 1'b0;
  endtask

  task automatic test_key_ignored;
    logic [127:0] ka, kb;
    int ok, bad;
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    send_key(ka, ok);
    key_in = kb;
    key_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (key_ready0 !== 1'b0 || busy0 !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL ignore_ready got %0d bad cycles exp 0", bad); end
    collect(25, -1);
    compute_ref(ka);
    checks++; if (ok !== 1 || timed_out !== 0 || n_hs !== 11) begin errors++; $display("FAIL ignore_count got %0d exp 11", n_hs); end
    for (int i = 0; i < 11; i++) begin
      checks++; if (got_rk[i] !== exp_rk[10-i] || got_round[i] !== 4'(10-i))
        begin errors++; $display("FAIL ignore_seq[%0d] got %h r%0d exp %h r%0d", i, got_rk[i], got_round[i], exp_rk[10-i], 10-i); end
    end
    checks++; if (key_ready0 !== 1'b1) begin errors++; $display("FAIL ignore_ready_end got %b exp 1", key_ready0); end
    @(posedge clk); #1;
    key_valid = 1'b0;
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL ignore_b_accept got busy %b exp 1", busy0); end
    collect(0, -1);
    compute_ref(kb);
    checks++; if (timed_out !== 0 || n_hs !== 11 || got_rk[0] !== exp_rk[10] || got_rk[10] !== kb)
      begin errors++; $display("FAIL ignore_b_seq got n=%0d r10=%h exp n=11 r10=%h", n_hs, got_rk[0], exp_rk[10]); end
  endtask

  task automatic test_back_to_back;
    logic [127:0] k1, k2;
    int ok;
    k1 = {$urandom, $urandom, $urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom, $urandom};
    send_key(k1, ok);
    key_in = k2;
    key_valid = 1'b1;
    collect(0, -1);
    checks++; if (ok !== 1 || n_hs !== 11 || got_cyc[10] !== 21) begin errors++; $display("FAIL b2b_first got n=%0d last@%0d exp 11 @21", n_hs, got_cyc[10]); end
    checks++; if (key_ready0 !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", key_ready0); end
    @(posedge clk); #1;
    key_valid = 1'b0;
    collect(0, -1);
    compute_ref(k2);
    checks++; if (timed_out !== 0 || n_hs !== 11 || got_cyc[0] !== 11) begin errors++; $display("FAIL b2b_second_latency got n=%0d first@%0d exp 11 @11", n_hs, got_cyc[0]); end
    for (int i = 0; i < 11; i++) begin
      checks++; if (got_rk[i] !== exp_rk[10-i] || got_round[i] !== 4'(10-i))
        begin errors++; $display("FAIL b2b_seq[%0d] got %h r%0d exp %h r%0d", i, got_rk[i], got_round[i], exp_rk[10-i], 10-i); end
    end
  endtask

  task automatic test_reset_mid;
    logic [127:0] k;
    int ok, seen;
    k = 128'h000102030405060708090a0b0c0d0e0f;
    send_key({$urandom, $urandom, $urandom, $urandom}, ok);
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (busy0 !== 1'b1 || rk_valid0 !== 1'b0) begin errors++; $display("FAIL rstmid_expand got busy=%b valid=%b exp 1 0", busy0, rk_valid0); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (rk_valid0 !== 1'b0 || key_ready0 !== 1'b1 || rk_out0 !== '0 || busy0 !== 1'b0 || rk_round0 !== 4'd0)
      begin errors++; $display("FAIL rstmid_expand_after got valid=%b ready=%b out=%h exp 0 1 0", rk_valid0, key_ready0, rk_out0); end
    send_key({$urandom, $urandom, $urandom, $urandom}, ok);
    collect(0, 6);
    checks++; if (timed_out !== 0 || n_hs !== 5 || got_round[4] !== 4'd6) begin errors++; $display("FAIL rstmid_emit_reach got n=%0d exp 5", n_hs); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (rk_valid0 !== 1'b0 || key_ready0 !== 1'b1 || rk_out0 !== '0 || rk_last0 !== 1'b0)
      begin errors++; $display("FAIL rstmid_emit_after got valid=%b ready=%b out=%h exp 0 1 0", rk_valid0, key_ready0, rk_out0); end
    seen = 0;
    repeat (3) begin if (rk_valid0 !== 1'b0) seen++; @(posedge clk); #1; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_abandon got %0d valid cycles exp 0", seen); end
    compute_ref(k);
    send_key(k, ok);
    collect(0, -1);
    checks++; if (timed_out !== 0 || n_hs !== 11 || got_cyc[0] !== 11) begin errors++; $display("FAIL rstmid_recover got n=%0d first@%0d exp 11 @11", n_hs, got_cyc[0]); end
    for (int i = 0; i < 11; i++) begin
      checks++; if (got_rk[i] !== exp_rk[10-i] || got_round[i] !== 4'(10-i))
        begin errors++; $display("FAIL rstmid_seq[%0d] got %h r%0d exp %h r%0d", i, got_rk[i], got_round[i], exp_rk[10-i], 10-i); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) sbt[i] = sbox_calc(8'(i));
    test_reset();
    test_decrypt_order();
    test_stall(128'h2b7e151628aed2a6abf7158809cf4f3c, 40, 1);
    for (int n = 0; n < 3; n++) test_stall({$urandom, $urandom, $urandom, $urandom}, 30, 0);
    test_fwd_order(128'h2b7e151628aed2a6abf7158809cf4f3c, 0);
    checks++; if (got_rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin errors++; $display("FAIL fwd_round10 got %h exp d014f9a8c9ee2589e13f0cc8b6630ca6", got_rk[10]); end
    test_fwd_order({$urandom, $urandom, $urandom, $urandom}, 35);
    test_key_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
